// File: rtl/intra8x8_pkg.sv
// Shared types and constants for the intra8x8 block sequencer.
// Holds the scheduler state encoding and block/macroblock geometry.
package intra8x8_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FRAMING,
    S_WAIT_RDY,
    S_SEND,
    S_WAIT_FB
  } sched_state_t;

  localparam int WORDS_PER_BLK = 16;
  localparam int BLKS_PER_MB   = 4;
  localparam int MB_W          = 8;

endpackage

// File: rtl/mb_pos_counter.sv
// Macroblock X/Y position counter for intra8x8_sched.
// Wraps X at end of row and flags the last macroblock of a frame.
module mb_pos_counter
  import intra8x8_pkg::*;
#(
  parameter int MBX_MAX = 120,
  parameter int MBY_MAX = 68
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clear,
  input  logic            i_advance,
  output logic [MB_W-1:0] o_mbx,
  output logic [MB_W-1:0] o_mby,
  output logic            o_row_wrap,
  output logic            o_last_mb
);

  logic [MB_W-1:0] r_mbx;
  logic [MB_W-1:0] r_mby;

  assign o_mbx      = r_mbx;
  assign o_mby      = r_mby;
  assign o_row_wrap = (r_mbx == MB_W'(MBX_MAX - 1));
  assign o_last_mb  = o_row_wrap &&
                      (r_mby == MB_W'(MBY_MAX - 1));

  // Step X, wrapping into the next row; last MB returns to origin.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_mbx <= '0;
      r_mby <= '0;
    end else if (i_advance) begin
      if (o_row_wrap) begin
        r_mbx <= '0;
        r_mby <= o_last_mb ? '0 : r_mby + 1'b1;
      end else begin
        r_mbx <= r_mbx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/intra8x8_sched.sv
// Block-level sequencer feeding the intra8x8 prediction datapath.
// Optional watchdog/ERR output: define INTRA8X8_SCHED_TIMEOUT_EN.
module intra8x8_sched
  import intra8x8_pkg::*;
#(
  parameter int MBX_MAX    = 120,
  parameter int MBY_MAX    = 68,
  parameter int FB_PER_BLK = 64
`ifdef INTRA8X8_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 1024
`endif
) (
  input  logic        CLK2,
  input  logic        RESET,
  input  logic        SLICE_START,
  input  logic        SRC_VALID,
  input  logic [31:0] SRC_DATA,
  output logic        SRC_READY,
  input  logic        DP_READYI,
  input  logic        DP_FBSTROBE,
  output logic        DP_STROBEI,
  output logic [31:0] DP_DATAI,
  output logic        DP_NEWSLICE,
  output logic        DP_NEWLINE,
  output logic        BUSY,
  output logic        MB_DONE,
  output logic        FRAME_DONE,
  output logic [7:0]  MBX,
  output logic [7:0]  MBY
`ifdef INTRA8X8_SCHED_TIMEOUT_EN
  ,
  output logic        ERR
`endif
);

  localparam int FB_W = $clog2(FB_PER_BLK + 1);

  sched_state_t    r_state;
  sched_state_t    w_next;
  sched_state_t    w_state_d;
  logic [3:0]      r_word_cnt;
  logic [1:0]      r_blk_cnt;
  logic [FB_W-1:0] r_fb_cnt;
  logic [FB_W-1:0] w_fb_inc;
  logic [31:0]     r_data;
  logic            w_accept;
  logic            w_start;
  logic            w_go;
  logic            w_fb_en;
  logic            w_blk_done;
  logic            w_mb_done;
  logic            w_row_wrap;
  logic            w_last_mb;
  logic            w_to_hit;

  assign w_start  = (r_state == S_IDLE) && SLICE_START;
  assign w_go     = (r_state == S_WAIT_RDY) && DP_READYI;
  assign w_accept = (r_state == S_SEND) && SRC_VALID;
  assign w_fb_en  = ((r_state == S_SEND) ||
                     (r_state == S_WAIT_FB)) &&
                    DP_FBSTROBE &&
                    (r_fb_cnt != FB_W'(FB_PER_BLK));
  assign w_fb_inc = r_fb_cnt + FB_W'(w_fb_en);

  assign w_blk_done = (r_state == S_WAIT_FB) &&
                      (w_fb_inc == FB_W'(FB_PER_BLK));
  assign w_mb_done  = w_blk_done &&
                      (r_blk_cnt == 2'(BLKS_PER_MB - 1));

  assign MB_DONE    = w_mb_done;
  assign FRAME_DONE = w_mb_done && w_last_mb;
  assign DP_DATAI   = w_accept ? SRC_DATA : r_data;
  assign w_state_d  = w_to_hit ? S_IDLE : w_next;

  mb_pos_counter #(
    .MBX_MAX (MBX_MAX),
    .MBY_MAX (MBY_MAX)
  ) u_pos (
    .i_clk      (CLK2),
    .i_rst      (RESET),
    .i_clear    (w_start),
    .i_advance  (w_mb_done),
    .o_mbx      (MBX),
    .o_mby      (MBY),
    .o_row_wrap (w_row_wrap),
    .o_last_mb  (w_last_mb)
  );

  // State register.
  always_ff @(posedge CLK2) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_d;
  end

  // Next-state decode and per-state framing/handshake outputs.
  always_comb begin
    w_next      = r_state;
    SRC_READY   = 1'b0;
    DP_STROBEI  = 1'b0;
    DP_NEWLINE  = 1'b0;
    DP_NEWSLICE = 1'b0;
    BUSY        = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE: begin
        if (SLICE_START) w_next = S_FRAMING;
      end
      S_FRAMING: begin
        DP_NEWLINE  = 1'b1;
        DP_NEWSLICE = (MBX == '0) && (MBY == '0);
        w_next      = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (DP_READYI) w_next = S_SEND;
      end
      S_SEND: begin
        SRC_READY  = 1'b1;
        DP_STROBEI = SRC_VALID;
        if (w_accept &&
            r_word_cnt == 4'(WORDS_PER_BLK - 1))
          w_next = S_WAIT_FB;
      end
      S_WAIT_FB: begin
        if (w_blk_done) begin
          if (!w_mb_done)     w_next = S_WAIT_RDY;
          else if (w_last_mb) w_next = S_IDLE;
          else if (w_row_wrap) w_next = S_FRAMING;
          else                w_next = S_WAIT_RDY;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Word, block and feedback counters plus last-word hold register.
  always_ff @(posedge CLK2) begin
    if (RESET) begin
      r_word_cnt <= '0;
      r_blk_cnt  <= '0;
      r_fb_cnt   <= '0;
      r_data     <= '0;
    end else begin
      if (w_go)          r_word_cnt <= '0;
      else if (w_accept) r_word_cnt <= r_word_cnt + 1'b1;
      if (w_start || w_go || w_blk_done) r_fb_cnt <= '0;
      else                               r_fb_cnt <= w_fb_inc;
      if (w_start)         r_blk_cnt <= '0;
      else if (w_blk_done) r_blk_cnt <= r_blk_cnt + 1'b1;
      if (w_accept) r_data <= SRC_DATA;
    end
  end

`ifdef INTRA8X8_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;
  logic            w_to_run;

  assign w_to_run = ((r_state == S_WAIT_FB) ||
                     (r_state == S_WAIT_RDY)) &&
                    !DP_FBSTROBE && (w_next == r_state);
  assign w_to_hit = w_to_run &&
                    (r_to_cnt == TO_W'(TIMEOUT - 1));
  assign ERR      = r_err;

  // Watchdog on stalled ready/feedback waits; error is sticky.
  always_ff @(posedge CLK2) begin
    if (RESET) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_to_cnt <= w_to_run ? r_to_cnt + 1'b1 : '0;
      if (w_start)       r_err <= 1'b0;
      else if (w_to_hit) r_err <= 1'b1;
    end
  end
`else
  assign w_to_hit = 1'b0;
`endif

endmodule

// File: doc/intra8x8_sched.md
Name: intra8x8_sched

Overview:
- Block-level sequencer in front of the intra8x8 prediction datapath.
- Pulls 32-bit pixel words (4 luma pixels each) from an upstream source and issues them to the datapath, 16 words per 8x8 block and 4 blocks per macroblock.
- Holds each next block until the datapath has returned all 64 reconstructed feedback pixels, which enforces the intra dependency.
- Generates the datapath's NEWSLICE/NEWLINE framing and tracks macroblock X/Y position across a frame.

Parameters:
- MBX_MAX, 120, macroblocks per row (1..255)
- MBY_MAX, 68, macroblock rows per frame (1..255)
- FB_PER_BLK, 64, FBSTROBE pulses expected per 8x8 block
- TIMEOUT, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
- CLK2  in  1  clock; all logic on posedge
- RESET  in  1  synchronous active-high reset
- SLICE_START  in  1  one-cycle pulse that starts a frame/slice
- SRC_VALID  in  1  upstream word valid
- SRC_DATA  in  32  upstream pixel word
- SRC_READY  out  1  upstream word accepted when SRC_VALID&SRC_READY
- DP_READYI  in  1  datapath ready to accept a new block
- DP_FBSTROBE  in  1  datapath feedback pixel strobe
- DP_STROBEI  out  1  word strobe to datapath
- DP_DATAI  out  32  word to datapath
- DP_NEWSLICE  out  1  slice-start pulse to datapath
- DP_NEWLINE  out  1  row-start pulse to datapath
- BUSY  out  1  high outside IDLE
- MB_DONE  out  1  one-cycle pulse when a macroblock's 4th block feedback completes
- FRAME_DONE  out  1  one-cycle pulse when the last macroblock completes
- MBX  out  8  current macroblock column
- MBY  out  8  current macroblock row

Behaviour:
- Clock and reset: one clock, CLK2; reset is synchronous and active-high (RESET).
- Reset values:
  - All outputs 0; MBX=MBY=0.
  - State=IDLE; word_cnt, blk_cnt and fb_cnt cleared.
  - RESET wins over every other input in the same cycle and aborts any block in flight.
- State machine (IDLE, FRAMING, WAIT_RDY, SEND, WAIT_FB):
  - IDLE: on SLICE_START go to FRAMING with MBX=MBY=0. SLICE_START in any other state is ignored.
  - FRAMING: one cycle. DP_NEWLINE=1. DP_NEWSLICE=1 only when MBX=0 and MBY=0. Then go to WAIT_RDY.
  - WAIT_RDY: when DP_READYI=1, clear word_cnt and fb_cnt and go to SEND.
  - SEND:
    - SRC_READY=1.
    - Each cycle with SRC_VALID=1: DP_STROBEI=1, DP_DATAI=SRC_DATA (combinational pass-through, zero latency), word_cnt++.
    - SRC_VALID=0 is a stall: no strobe, counters hold, DP_DATAI holds its last value.
    - After the 16th word go to WAIT_FB.
  - WAIT_FB:
    - When fb_cnt reaches FB_PER_BLK: blk_cnt++.
    - If blk_cnt was 3: pulse MB_DONE and advance MBX.
      - On MBX wrap (MBX_MAX-1 -> 0), advance MBY and go to FRAMING.
      - On the final macroblock, pulse FRAME_DONE and go to IDLE.
    - Otherwise go to WAIT_RDY.
- Feedback counting:
  - fb_cnt increments on DP_FBSTROBE in SEND and WAIT_FB, so feedback may start before the last word is sent.
  - fb_cnt saturates at FB_PER_BLK.
  - DP_FBSTROBE in IDLE, FRAMING or WAIT_RDY is ignored.
  - A strobe in the same cycle as the WAIT_FB exit is counted toward the completed block and discarded.
- Latency: at least 17 cycles per block (1 in WAIT_RDY + 16 in SEND), plus feedback time.
- SRC_READY=0 in every state except SEND.
- MB_DONE and FRAME_DONE both pulse in the cycle the final feedback is counted. MBX/MBY update on the next edge.

Optional Feature:
- Macro: INTRA8X8_SCHED_TIMEOUT_EN.
- With the macro defined:
  - Add output ERR (1 bit).
  - A cycle counter runs in WAIT_FB and WAIT_RDY and clears on any DP_FBSTROBE or state change.
  - If it reaches TIMEOUT: ERR is set sticky, the state goes to IDLE, and no MB_DONE/FRAME_DONE pulse is issued.
  - ERR clears only on RESET or the next accepted SLICE_START.
- Without the macro: no ERR port and no counter; the block waits indefinitely.

Decomposition:
- Package intra8x8_pkg holds:
  - state enum sched_state_t
  - constants WORDS_PER_BLK=16 and BLKS_PER_MB=4
  - widths for MB counters
- Sub-module mb_pos_counter:
  - MBX/MBY counter with row-wrap and last-macroblock flags
  - inputs: advance, clear
  - outputs: MBX, MBY, row_wrap, last_mb

Test Plan:
- Reset mid-SEND:
  - Stimulus: assert RESET after 5 words.
  - Response: next cycle all outputs 0 and state IDLE. A new SLICE_START restarts with DP_NEWSLICE=1 and MBX=MBY=0.
- Single macroblock (MBX_MAX=1, MBY_MAX=1):
  - Stimulus: SLICE_START, SRC_VALID held high with incrementing data from 32'h00000001, 64 FBSTROBEs per block.
  - Response: exactly 64 DP_STROBEI, DP_DATAI sequence 1..64, one MB_DONE and FRAME_DONE pulse in the same cycle, then BUSY=0.
- Stalls:
  - Stimulus: toggle SRC_VALID 1,0,1,0 during SEND with data 32'h87654321 / 32'h12345678.
  - Response: DP_STROBEI only when SRC_VALID=1, word_cnt reaches 16 after 32 cycles, no duplicated or dropped words.
- Feedback gating:
  - Stimulus: hold DP_READYI=1, send only 63 FBSTROBEs.
  - Response: no second-block DP_STROBEI. The 64th strobe releases WAIT_RDY on the next cycle.
- Row framing (MBX_MAX=2, MBY_MAX=2):
  - Response: DP_NEWSLICE exactly once, DP_NEWLINE at MBY=0 and MBY=1 starts, MBX sequence 0,1,0,1, FRAME_DONE after the 4th MB_DONE.
- Ignored events:
  - Stimulus: SLICE_START during SEND, FBSTROBE during WAIT_RDY.
  - Response: no state change, fb_cnt stays 0.
  - With INTRA8X8_SCHED_TIMEOUT_EN and TIMEOUT=16: no feedback -> ERR=1 after 16 cycles, BUSY=0.
